matrix_loader: RTL
==================

Name: matrix_loader

Overview:
- Upstream feeder for matrix_mult.
- Accepts a stream of 16-bit elements over a valid/ready handshake and assembles two packed 4x4 operand matrices, m1 then m2.
- Raises enable to the multiplier, holds both operands stable until the multiplier's done flag rises, then reopens for the next pair.
- Turns a narrow memory/bus interface into the 256-bit parallel operands matrix_mult consumes.

Parameters:
- DW, 16, element width in bits.
- DIM, 4, matrix dimension; the matrix has DIM*DIM elements.
- MAT_W, DW*DIM*DIM (256), packed matrix width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  DW  element word.
- in_valid  input  1  in_data valid this cycle.
- in_first  input  1  qualifies the beat as element 0 of m1 (frame start).
- in_ready  output  1  loader can accept a beat.
- m1  output  MAT_W  packed operand 1, to matrix_mult m1.
- m2  output  MAT_W  packed operand 2, to matrix_mult m2.
- enable  output  1  start/hold to matrix_mult enable.
- mult_done  input  1  matrix_mult done flag.
- busy  output  1  high while the multiplier is running (state RUN).
- frame_err  output  1  one-cycle pulse on a resynchronising in_first.
- pair_count  output  8  completed multiplications, wraps 255->0.

Behaviour:
- Reset (reset low, async):
  - State LOAD_A, idx=0.
  - m1=0, m2=0, enable=0, busy=0, frame_err=0, pair_count=0, in_ready=1.
- Handshake:
  - A beat is accepted on a rising clk when in_valid && in_ready.
  - in_ready = (state==LOAD_A || state==LOAD_B); it is decoded from registered state only, with no combinational path from inputs.
- Packing (row-major stream):
  - Element k (0..15) of a matrix is row=k/DIM, col=k%DIM.
  - It is written to bits [col*DW + row*DIM*DW + DW-1 -: DW], i.e. bits [k*16+15 : k*16].
  - Element [0][0] occupies m[15:0].
- State machine, 4-bit idx counter:
  - LOAD_A: each accepted beat writes m1 element idx and increments idx. On accepting idx==15: idx<=0, go to LOAD_B.
  - LOAD_B: each accepted beat writes m2 element idx and increments idx. On accepting idx==15: idx<=0, enable<=1, busy<=1, go to RUN.
  - RUN: in_ready=0. m1/m2 frozen. enable held at 1. done_q registers mult_done.
  - RUN exit: on the first cycle with mult_done==1 && done_q==0 (rising edge), enable<=0, busy<=0, pair_count<=pair_count+1, go to LOAD_A.
  - A stale high done present on RUN entry is ignored until it is seen low.
- Latency:
  - The 32nd accepted beat causes enable=1 on the same edge (registered output).
  - After the mult_done rise, enable falls on the next edge, and in_ready returns 1 on that same edge.
- in_first:
  - Accepted with idx==0 in LOAD_A: normal start, no error.
  - Accepted in LOAD_B, or in LOAD_A with idx!=0: abort the partial load. The beat becomes m1 element 0, idx<=1, state LOAD_A, frame_err pulses 1 for one cycle.
  - Previously written elements are not cleared, only overwritten.
  - In RUN: ignored, since no beat is accepted.
- Async reset mid-RUN: enable drops immediately; the multiplier sees enable low.
- mult_done outside RUN: ignored.
- Simultaneous in_first and final beat: the in_first rule wins (restart).

Optional Feature:
- MATRIX_LOADER_TRANSPOSE_EN.
- Defined: m2 elements are taken column-major. Element k goes to row=k%DIM, col=k/DIM, so the source supplies B^T rows.
- m1 is always row-major.
- Undefined: both matrices are row-major. There is no extra logic and no extra ports.

Decomposition:
- Package matrix_pkg holds:
  - DW, DIM, MAT_W.
  - The state typedef (LOAD_A, LOAD_B, RUN).
  - An element-offset function (row, col -> bit LSB).
- matrix_mult and the benches share matrix_pkg.
- One natural sub-module: matrix_pack_reg. It is a MAT_W register with a write enable, 4-bit index and DW data, and it applies the offset mapping.
- matrix_loader instantiates matrix_pack_reg twice, once for m1 and once for m2.

Test Plan:
- Basic load:
  - Stimulus: stream 5,8,9,2,7,3,8,4,6,5,4,3,8,5,7,6 then 11,14,19,18,6,9,3,5,12,10,15,14,1,3,5,7, valid every cycle.
  - Expect m1[15:0]=5, m1[31:16]=8, m1[79:64]=7, m2[15:0]=11, m2[79:64]=6.
  - Expect enable=1 right after beat 32, in_ready=0.
- Done handshake:
  - Stimulus: hold mult_done=0 for 10 cycles, then 1.
  - Expect m1/m2 unchanged and enable=1 throughout.
  - Expect enable=0 and in_ready=1 one edge after the rise, pair_count=1.
- Backpressure and gaps:
  - Stimulus: random in_valid gaps, plus in_valid during RUN.
  - Expect no beats lost or duplicated and no writes in RUN; same operands as the basic load.
- Resync:
  - Stimulus: in_first at m2 element 5 with data 42.
  - Expect a single frame_err pulse, m1[15:0]=42, state LOAD_A, idx=1. Reloading 31 more beats fires enable.
- Reset mid-RUN and stale done:
  - Stimulus: reset low during RUN.
  - Expect enable=0 asynchronously and all outputs at reset values.
  - Then load a pair with mult_done stuck at 1: enable stays high until done goes 0 then 1.
- Transpose (MATRIX_LOADER_TRANSPOSE_EN defined):
  - Stimulus: basic load.
  - Expect m2[79:64]=14, m2[31:16]=6, m1 unchanged from the basic load.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix loader and its consumers: element and
// matrix widths, the loader state encoding, and the element-offset mapping.
package matrix_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned DIM   = 4;
    localparam int unsigned MAT_W = DW * DIM * DIM;
    localparam int unsigned IDX_W = $clog2(DIM * DIM);
    localparam int unsigned LSB_W = $clog2(MAT_W);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM * DIM - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2
    } state_t;

    // Bit position of element [row][col] inside a packed matrix; [0][0] sits at bit 0.
    function automatic logic [LSB_W-1:0] elem_lsb(input int unsigned row, input int unsigned col);
        int unsigned lsb;
        lsb = col * DW + row * DIM * DW;
        return lsb[LSB_W-1:0];
    endfunction

endpackage

// File: rtl/matrix_pack_reg.sv
// One packed DIMxDIM operand register. A stream index selects the element;
// COL_MAJOR picks whether the index walks rows (0) or columns (1).
module matrix_pack_reg
    import matrix_pkg::*;
#(
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [DW-1:0]    wr_data,
    output logic [MAT_W-1:0] q
);

    int unsigned      row;
    int unsigned      col;
    logic [LSB_W-1:0] lsb;

    // Map the stream index onto a row/column pair.
    always_comb begin
        if (COL_MAJOR) begin
            row = 32'(wr_idx) % DIM;
            col = 32'(wr_idx) / DIM;
        end else begin
            row = 32'(wr_idx) / DIM;
            col = 32'(wr_idx) % DIM;
        end
    end

    assign lsb = elem_lsb(row, col);

    // Write one element; untouched elements keep their previous value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (wr_en) begin
            q[lsb +: DW] <= wr_data;
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Streams 16-bit elements into two packed 4x4 operands (m1 then m2), starts
// the multiplier with enable, and holds the operands until done rises.
//
// Handshake: a beat transfers on a rising clk where in_valid && in_ready;
// in_ready is decoded only from registered state, so it never depends on
// any input in the same cycle. in_valid may be asserted at any time and is
// simply ignored while in_ready is low.
//
// Build option: define MATRIX_LOADER_TRANSPOSE_EN to take m2 column-major
// (the source streams the rows of B^T); m1 is always row-major.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    input  logic             in_first,
    output logic             in_ready,
    output logic [MAT_W-1:0] m1,
    output logic [MAT_W-1:0] m2,
    output logic             enable,
    input  logic             mult_done,
    output logic             busy,
    output logic             frame_err,
    output logic [7:0]       pair_count,
    output state_t           fsm_state,
    output logic [IDX_W-1:0] idx
);

`ifdef MATRIX_LOADER_TRANSPOSE_EN
    localparam bit M2_COL_MAJOR = 1'b1;
`else
    localparam bit M2_COL_MAJOR = 1'b0;
`endif

    logic             accept;
    logic             resync;
    logic             m1_we;
    logic             m2_we;
    logic [IDX_W-1:0] m1_idx;
    logic             done_q;

    assign in_ready = (fsm_state == LOAD_A) || (fsm_state == LOAD_B);
    assign accept   = in_valid && in_ready;

    // A frame start anywhere other than m1 element 0 restarts the load.
    assign resync = accept && in_first && ((fsm_state == LOAD_B) || (idx != '0));

    // A restarting beat always lands in m1 element 0, even from LOAD_B.
    assign m1_we  = accept && ((fsm_state == LOAD_A) || in_first);
    assign m1_idx = resync ? '0 : idx;
    assign m2_we  = accept && (fsm_state == LOAD_B) && !in_first;

    matrix_pack_reg #(.COL_MAJOR(1'b0)) u_m1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (m1_we),
        .wr_idx  (m1_idx),
        .wr_data (in_data),
        .q       (m1)
    );

    matrix_pack_reg #(.COL_MAJOR(M2_COL_MAJOR)) u_m2 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (m2_we),
        .wr_idx  (idx),
        .wr_data (in_data),
        .q       (m2)
    );

    // Load/run sequencer with registered enable, busy, error pulse and pair counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_state  <= LOAD_A;
            idx        <= '0;
            enable     <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            pair_count <= '0;
            done_q     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // Tracking done continuously means a done already high at RUN
            // entry must drop before a new rise can end the run.
            done_q    <= mult_done;
            case (fsm_state)
                LOAD_A: begin
                    if (accept) begin
                        if (resync) begin
                            idx       <= IDX_W'(1);
                            frame_err <= 1'b1;
                        end else if (idx == IDX_LAST) begin
                            idx       <= '0;
                            fsm_state <= LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (resync) begin
                            idx       <= IDX_W'(1);
                            frame_err <= 1'b1;
                            fsm_state <= LOAD_A;
                        end else if (idx == IDX_LAST) begin
                            idx       <= '0;
                            enable    <= 1'b1;
                            busy      <= 1'b1;
                            fsm_state <= RUN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (mult_done && !done_q) begin
                        enable     <= 1'b0;
                        busy       <= 1'b0;
                        pair_count <= pair_count + 1'b1;
                        fsm_state  <= LOAD_A;
                    end
                end
                default: fsm_state <= LOAD_A;
            endcase
        end
    end

endmodule
